imem_loader: RTL
================

Name: imem_loader

Overview:
- Byte-stream program loader that writes the instruction memory before the core runs.
- Consumes a framed byte stream (length, payload, checksum) from a host link such as a UART RX, and assembles little-endian 32-bit instruction words.
- Issues one word-indexed write per word into the instruction memory's write port.
- Holds the pipeline in reset until a frame loads cleanly.

Parameters:
- DEPTH, 64, number of 32-bit instruction words in instruction memory.
- AW, $clog2(DEPTH), width of the word index driven on the write port.

Ports:
- clk  input  1  single clock for the whole block.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  byte available on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle; a transfer occurs when in_valid && in_ready.
- restart  input  1  single-cycle request to reload; honoured only in DONE or ERR.
- mem_we  output  1  one-cycle write strobe to instruction memory.
- mem_waddr  output  AW  word index, equal to byte address >> 2.
- mem_wdata  output  32  assembled instruction word.
- cpu_rst_n  output  1  active-low reset to the pipeline; low until a load completes.
- load_done  output  1  frame loaded and checksum matched.
- load_err  output  1  frame rejected.
- words_loaded  output  AW+1  count of words written in the current frame.

Behaviour:
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N payload bytes, then CSUM.
  - CSUM is the 8-bit modulo-256 sum of all payload bytes.
  - Length bytes are not included in CSUM.
- Reset values: state LEN_LO, mem_we 0, mem_waddr 0, mem_wdata 0, cpu_rst_n 0, load_done 0, load_err 0, words_loaded 0, in_ready 1. All internal byte index, word, length and sum registers are 0.
- in_ready is 1 in LEN_LO, LEN_HI, DATA and CSUM; it is 0 in DONE and ERR. in_ready is combinational from state only, never from in_valid.
- State transitions (each on an accepted byte unless noted):
  - LEN_LO: capture len[7:0]; go to LEN_HI.
  - LEN_HI: capture len[15:8].
    - If {in_data,len[7:0]} == 0 or > DEPTH, go to ERR.
    - Otherwise go to DATA with byte index 0, word index 0, sum 0.
  - DATA: shift the byte into lane byte_idx (byte 0 is bits 7:0), add it to sum, and increment byte_idx mod 4.
    - On the 4th byte, the next cycle has mem_we=1, mem_wdata = the assembled word, mem_waddr = word index. The word index and words_loaded then increment.
    - After the 4th byte of word N-1, go to CSUM.
  - CSUM: if in_data == sum, go to DONE; otherwise go to ERR.
  - DONE: load_done=1 and cpu_rst_n=1, registered, so both rise the cycle after the CSUM byte is accepted.
  - ERR: load_err=1 and cpu_rst_n=0.
  - DONE/ERR with restart=1: go to LEN_LO on the next edge. Clear load_done, load_err and words_loaded, and drive cpu_rst_n=0 in that same edge.
- Write latency: mem_we is asserted exactly 1 cycle after the 4th byte of a word is accepted and lasts 1 cycle. mem_waddr and mem_wdata are stable while mem_we=1.
- Back-to-back bytes at full rate (in_valid held high) are accepted every cycle with no bubble; the pending write does not stall the input.
- in_valid low between bytes holds all state; gaps of any length are legal.
- Words already written before an ERR stay in memory; cpu_rst_n stays low regardless.
- restart in LEN_LO, LEN_HI, DATA or CSUM is ignored.
- rst_n asserted mid-frame: everything returns to reset values immediately (asynchronously), and a partially assembled word is discarded with no write.
- Width rules: sum wraps mod 256; the word index never exceeds DEPTH-1 because the length check guarantees it; the length compare is 16-bit against DEPTH.

Decomposition:
- Shared package holds:
  - the state enum {LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR};
  - constants BYTES_PER_WORD=4 and LEN_BYTES=2;
  - the IMEM_DEPTH default, shared with the instruction memory.
- One natural sub-module, imem_word_assembler: byte_idx counter, lane shift, running checksum, and a word_ready pulse.
- The FSM, length check and write-port registers stay in imem_loader.

Test Plan:
- Stream 02 00 | 13 00 00 00 | 93 00 10 00 | B6 at full rate:
  - writes 0x00000013 to index 0, then 0x00100093 to index 1, each mem_we one cycle after its 4th byte;
  - CSUM 0xB6 matches;
  - load_done=1, cpu_rst_n=1 one cycle after the CSUM byte; words_loaded=2.
- Same frame with random 0-5 cycle in_valid gaps: identical writes and final state, no extra mem_we pulses.
- Length 41 00 with DEPTH=64: ERR after LEN_HI, no mem_we, in_ready=0, load_err=1. Length 00 00 also gives ERR.
- Valid 1-word frame with CSUM off by one: one write occurs, then ERR with cpu_rst_n=0. A restart pulse returns to LEN_LO with load_err=0, and a correct frame then reaches DONE.
- Drop rst_n after 6 bytes of a 2-word frame: outputs reset asynchronously, no second write; a fresh full frame then loads correctly.
- restart pulsed during DATA: ignored, frame completes normally; restart in DONE drops cpu_rst_n and load_done on the next edge.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader and the
// instruction memory it feeds.
package imem_loader_pkg;

   localparam int IMEM_DEPTH     = 64;
   localparam int BYTES_PER_WORD = 4;
   localparam int LEN_BYTES      = 2;
   localparam int LEN_W          = LEN_BYTES * 8;
   localparam int BIDX_W         = $clog2(BYTES_PER_WORD);

   typedef enum logic [2:0] {
      LEN_LO = 3'd0,
      LEN_HI = 3'd1,
      DATA   = 3'd2,
      CSUM   = 3'd3,
      DONE   = 3'd4,
      ERR    = 3'd5
   } state_e;

   // Frame checksum is a plain modulo-256 byte sum.
   function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
      return sum + b;
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if #(
   parameter int AW = $clog2(imem_loader_pkg::IMEM_DEPTH)
) ();
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [31:0]   mem_wdata;

   modport master (
      output in_valid, in_data,
      input  in_ready, mem_we, mem_waddr, mem_wdata
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, mem_we, mem_waddr, mem_wdata
   );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs payload bytes little-endian into 32-bit words and keeps the running
// payload checksum; word_ready_o flags the byte that completes a word.
module imem_word_assembler
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   output logic        word_ready_o,
   output logic [31:0] word_o,
   output logic [7:0]  sum_o
);

   logic [BIDX_W-1:0] byte_idx_q;
   logic [31:0]       word_q;
   logic [7:0]        sum_q;
   logic [31:0]       word_merge_s;

   // Current word with the incoming byte dropped into its lane.
   always_comb begin
      word_merge_s = word_q;
      word_merge_s[{byte_idx_q, 3'b000} +: 8] = byte_i;
   end

   assign word_ready_o = byte_valid_i && (byte_idx_q == BIDX_W'(BYTES_PER_WORD - 1));
   assign word_o       = word_merge_s;
   assign sum_o        = sum_q;

   // Lane index, partial word and checksum state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_idx_q <= '0;
         word_q     <= 32'h0000_0000;
         sum_q      <= 8'h00;
      end else if (clear_i) begin
         byte_idx_q <= '0;
         word_q     <= 32'h0000_0000;
         sum_q      <= 8'h00;
      end else if (byte_valid_i) begin
         byte_idx_q <= byte_idx_q + 1'b1;
         word_q     <= word_merge_s;
         sum_q      <= csum_add(sum_q, byte_i);
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Frame loader: parses LEN/payload/CSUM from a byte stream, writes each word
// into instruction memory and releases the core only after a clean load.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH = IMEM_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   imem_loader_if.slave  bus,
   input  logic          restart,
   output logic          cpu_rst_n,
   output logic          load_done,
   output logic          load_err,
   output logic [AW:0]   words_loaded
);

   state_e           state_q;
   logic [LEN_W-1:0] len_q;
   logic [AW-1:0]    widx_q;
   logic [AW:0]      words_q;
   logic             mem_we_q;
   logic [AW-1:0]    mem_waddr_q;
   logic [31:0]      mem_wdata_q;
   logic             cpu_rst_n_q;
   logic             done_q;
   logic             err_q;

   logic             in_ready_s;
   logic             accept_s;
   logic [LEN_W-1:0] len_full_s;
   logic             len_bad_s;
   logic             last_word_s;
   logic             word_ready_s;
   logic [31:0]      word_s;
   logic [7:0]       sum_s;

   assign in_ready_s  = (state_q != DONE) && (state_q != ERR);
   assign accept_s    = bus.in_valid && in_ready_s;
   assign len_full_s  = {bus.in_data, len_q[7:0]};
   assign len_bad_s   = (len_full_s == {LEN_W{1'b0}}) || (len_full_s > LEN_W'(DEPTH));
   assign last_word_s = (LEN_W'(widx_q) == (len_q - 1'b1));

   imem_word_assembler u_asm (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear_i      (accept_s && (state_q == LEN_HI)),
      .byte_valid_i (accept_s && (state_q == DATA)),
      .byte_i       (bus.in_data),
      .word_ready_o (word_ready_s),
      .word_o       (word_s),
      .sum_o        (sum_s)
   );

   // Frame FSM with registered write port and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= LEN_LO;
         len_q       <= {LEN_W{1'b0}};
         widx_q      <= '0;
         words_q     <= '0;
         mem_we_q    <= 1'b0;
         mem_waddr_q <= '0;
         mem_wdata_q <= 32'h0000_0000;
         cpu_rst_n_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         mem_we_q <= 1'b0;
         case (state_q)
            LEN_LO: if (accept_s) begin
               len_q[7:0] <= bus.in_data;
               state_q    <= LEN_HI;
            end
            LEN_HI: if (accept_s) begin
               len_q[15:8] <= bus.in_data;
               if (len_bad_s) begin
                  state_q <= ERR;
                  err_q   <= 1'b1;
               end else begin
                  state_q <= DATA;
                  widx_q  <= '0;
               end
            end
            // The length check bounds widx_q below DEPTH, so no wrap guard.
            DATA: if (word_ready_s) begin
               mem_we_q    <= 1'b1;
               mem_waddr_q <= widx_q;
               mem_wdata_q <= word_s;
               widx_q      <= widx_q + 1'b1;
               words_q     <= words_q + 1'b1;
               if (last_word_s) begin
                  state_q <= CSUM;
               end
            end
            CSUM: if (accept_s) begin
               if (bus.in_data == sum_s) begin
                  state_q     <= DONE;
                  done_q      <= 1'b1;
                  cpu_rst_n_q <= 1'b1;
               end else begin
                  state_q <= ERR;
                  err_q   <= 1'b1;
               end
            end
            DONE, ERR: if (restart) begin
               state_q     <= LEN_LO;
               len_q       <= {LEN_W{1'b0}};
               widx_q      <= '0;
               words_q     <= '0;
               cpu_rst_n_q <= 1'b0;
               done_q      <= 1'b0;
               err_q       <= 1'b0;
            end
            default: state_q <= LEN_LO;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_waddr = mem_waddr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign cpu_rst_n     = cpu_rst_n_q;
   assign load_done     = done_q;
   assign load_err      = err_q;
   assign words_loaded  = words_q;

endmodule
